// File: rtl/trap_filter_ctrl_pkg.sv
// rtl/trap_filter_ctrl_pkg.sv - shared sizes, filter latency, controller state type and config check
package package_settings_V1;

   localparam int SIZE_IN_DATA = 16;
   localparam int SIZE_CNT     = 8;
   localparam int DEPTH        = 64;
   localparam int SIZE_M       = 16;
   localparam int FILTER_LAT   = 5;

   typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} trap_ctrl_state_t;

   localparam logic [SIZE_CNT:0] MAX_SUM = (SIZE_CNT+1)'(DEPTH - 1);

   // The extra sum bit keeps k+l from wrapping back under the limit.
   function automatic logic cfg_is_valid(input logic [SIZE_CNT-1:0] k, input logic [SIZE_CNT-1:0] l);
      logic [SIZE_CNT:0] sum;
      sum = {1'b0, k} + {1'b0, l};
      return (k != '0) && (l >= k) && (sum <= MAX_SUM);
   endfunction

endpackage

// File: rtl/trap_filter_ctrl_peak.sv
// rtl/trap_filter_ctrl_peak.sv - above-threshold running-maximum tracker, emits one peak per pulse
import package_settings_V1::*;

module trap_peak_capture #(
   parameter int W        = SIZE_IN_DATA,
   parameter int PEAK_THR = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_run,
   input  logic [W-1:0] flt_data,
   output logic [W-1:0] peak_data,
   output logic         peak_valid
);

   logic         active;
   logic [W-1:0] max_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active     <= 1'b0;
         max_q      <= '0;
         peak_data  <= '0;
         peak_valid <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         if (!in_run) begin
            active <= 1'b0;
            max_q  <= '0;
         end else if (flt_data > W'(PEAK_THR)) begin
            active <= 1'b1;
            if (flt_data > max_q) max_q <= flt_data;
         end else if (active) begin
            peak_data  <= max_q;
            peak_valid <= 1'b1;
            active     <= 1'b0;
            max_q      <= '0;
         end
      end
   end

endmodule

// File: rtl/trap_filter_ctrl.sv
// rtl/trap_filter_ctrl.sv - trapezoidal filter run/config sequencer (flush, settle, run)
// Optional peak capture enabled by defining TRAP_PEAK_CAPTURE_EN.
import package_settings_V1::*;

module trap_filter_ctrl #(
   parameter int FLUSH_CYC = 2,
   parameter int K_DEF     = 4,
   parameter int L_DEF     = 8,
   parameter int M_DEF     = 16,
   parameter int PEAK_THR  = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run_en,
   input  logic                    cfg_valid,
   input  logic [SIZE_CNT-1:0]     cfg_k,
   input  logic [SIZE_CNT-1:0]     cfg_l,
   input  logic [SIZE_M-1:0]       cfg_m,
   output logic                    cfg_ready,
   output logic                    cfg_err,
   output logic                    flt_rst_n,
   output logic [SIZE_CNT-1:0]     flt_k,
   output logic [SIZE_CNT-1:0]     flt_l,
   output logic [SIZE_M-1:0]       flt_m,
   input  logic [SIZE_IN_DATA-1:0] flt_data,
   output logic                    out_valid,
   output logic                    busy,
   output logic [SIZE_IN_DATA-1:0] peak_data,
   output logic                    peak_valid
);

   localparam int CW = SIZE_CNT + 2;

   trap_ctrl_state_t state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             xfer, cfg_ok, apply;
   logic [CW-1:0]    flush_load, settle_load;

   assign flush_load  = CW'(FLUSH_CYC - 1);
   assign settle_load = CW'(flt_k) + CW'(flt_l) + CW'(FILTER_LAT - 1);
   assign xfer        = cfg_valid && cfg_ready;
   assign cfg_ok      = cfg_is_valid(cfg_k, cfg_l);
   assign apply       = xfer && cfg_ok;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (run_en) begin
               state_nx = FLUSH;
               cnt_nx   = flush_load;
            end
         end
         FLUSH: begin
            if (!run_en) state_nx = IDLE;
            else if (cnt == '0) begin
               state_nx = SETTLE;
               cnt_nx   = settle_load;
            end else cnt_nx = cnt - 1'b1;
         end
         SETTLE: begin
            if (!run_en) state_nx = IDLE;
            else if (cnt == '0) state_nx = RUN;
            else cnt_nx = cnt - 1'b1;
         end
         RUN: begin
            // Stop wins over a re-flush; the accepted config is still latched below.
            if (!run_en) state_nx = IDLE;
            else if (apply) begin
               state_nx = FLUSH;
               cnt_nx   = flush_load;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         flt_rst_n <= 1'b0;
         flt_k     <= SIZE_CNT'(K_DEF);
         flt_l     <= SIZE_CNT'(L_DEF);
         flt_m     <= SIZE_M'(M_DEF);
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         flt_rst_n <= (state_nx == SETTLE) || (state_nx == RUN);
         busy      <= (state_nx == FLUSH) || (state_nx == SETTLE);
         out_valid <= (state_nx == RUN);
         cfg_ready <= (state_nx == IDLE) || (state_nx == RUN);
         cfg_err   <= xfer && !cfg_ok;
         if (apply) begin
            flt_k <= cfg_k;
            flt_l <= cfg_l;
            flt_m <= cfg_m;
         end
      end
   end

`ifdef TRAP_PEAK_CAPTURE_EN
   trap_peak_capture #(
      .W        (SIZE_IN_DATA),
      .PEAK_THR (PEAK_THR)
   ) u_peak (
      .clk        (clk),
      .reset      (reset),
      .in_run     (state == RUN),
      .flt_data   (flt_data),
      .peak_data  (peak_data),
      .peak_valid (peak_valid)
   );
`else
   logic unused_flt_data;
   assign unused_flt_data = ^flt_data;
   assign peak_data       = '0;
   assign peak_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_trap_filter_ctrl.sv
// tb/tb_trap_filter_ctrl.sv - scoreboard bench for trap_filter_ctrl against a phase/timer reference model
`timescale 1ns/1ps

module tb_trap_filter_ctrl;

   localparam int K_DEF = 4, L_DEF = 8, M_DEF = 16, FLUSH_CYC = 2, THR = 64, LAT = 5, DEPTH = 64;
`ifdef TRAP_PEAK_CAPTURE_EN
   localparam bit PEAK_ON = 1'b1;
`else
   localparam bit PEAK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_k = '0, cfg_l = '0;
   logic [15:0] cfg_m = '0;
   logic [15:0] flt_data = '0;
   logic        cfg_ready, cfg_err, flt_rst_n, out_valid, busy, peak_valid;
   logic [7:0]  flt_k, flt_l;
   logic [15:0] flt_m, peak_data;

   trap_filter_ctrl dut (
      .clk(clk), .reset(reset), .run_en(run_en), .cfg_valid(cfg_valid),
      .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .flt_rst_n(flt_rst_n), .flt_k(flt_k), .flt_l(flt_l), .flt_m(flt_m), .flt_data(flt_data),
      .out_valid(out_valid), .busy(busy), .peak_data(peak_data), .peak_valid(peak_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ready, err, rstn, ov, busy, k, l, m, pd, pv;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: phase 0=stopped, 1=flushing, 2=settling, 3=running; left = cycles remaining in phase.
   int phase = 0, left = 0;
   int ak = K_DEF, al = L_DEF, am = M_DEF;
   int pk_act = 0, pk_max = 0, pd = 0, pv = 0, err = 0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model(input bit rst, input bit run, input bit cv,
                        input int k, input int l, input int m, input int d);
      bit xfer, ok;
      exp_t e;
      if (!rst) begin
         phase = 0; left = 0; ak = K_DEF; al = L_DEF; am = M_DEF;
         pk_act = 0; pk_max = 0; pd = 0; pv = 0; err = 0;
      end else begin
         xfer = cv && (phase == 0 || phase == 3);
         ok   = (k >= 1) && (l >= k) && (k + l <= DEPTH - 1);
         err  = (xfer && !ok) ? 1 : 0;
         pv   = 0;
         if (PEAK_ON) begin
            if (phase != 3) begin
               pk_act = 0; pk_max = 0;
            end else if (d > THR) begin
               pk_act = 1;
               if (d > pk_max) pk_max = d;
            end else if (pk_act != 0) begin
               pd = pk_max; pv = 1; pk_act = 0; pk_max = 0;
            end
         end
         if (xfer && ok) begin
            ak = k; al = l; am = m;
         end
         case (phase)
            0: if (run) begin phase = 1; left = FLUSH_CYC; end
            1, 2: begin
               if (!run) phase = 0;
               else begin
                  left--;
                  if (left == 0) begin
                     if (phase == 1) begin phase = 2; left = ak + al + LAT; end
                     else phase = 3;
                  end
               end
            end
            default: begin
               if (!run) phase = 0;
               else if (xfer && ok) begin phase = 1; left = FLUSH_CYC; end
            end
         endcase
      end
      e.ready = (phase == 0 || phase == 3);
      e.err   = err;
      e.rstn  = (phase >= 2);
      e.ov    = (phase == 3);
      e.busy  = (phase == 1 || phase == 2);
      e.k = ak; e.l = al; e.m = am; e.pd = pd; e.pv = pv;
      q.push_back(e);
   endtask

   task automatic step(input bit rst, input bit run, input bit cv,
                       input int k, input int l, input int m, input int d);
      bit fell;
      @(posedge clk);
      #3;
      fell      = reset && !rst;
      reset     = rst;
      run_en    = run;
      cfg_valid = cv;
      cfg_k     = 8'(k);
      cfg_l     = 8'(l);
      cfg_m     = 16'(m);
      flt_data  = 16'(d);
      if (fell) begin
         #1;
         chk("async_rst_flt_rst_n", int'(flt_rst_n), 0);
         chk("async_rst_cfg_ready", int'(cfg_ready), 1);
         chk("async_rst_busy", int'(busy), 0);
         chk("async_rst_out_valid", int'(out_valid), 0);
         chk("async_rst_flt_k", int'(flt_k), K_DEF);
         chk("async_rst_flt_l", int'(flt_l), L_DEF);
         chk("async_rst_flt_m", int'(flt_m), M_DEF);
         chk("async_rst_cfg_err", int'(cfg_err), 0);
         chk("async_rst_peak_valid", int'(peak_valid), 0);
         chk("async_rst_peak_data", int'(peak_data), 0);
      end
      model(rst, run, cv, k, l, m, d);
   endtask

   task automatic idle_run(input bit run, input int n);
      for (int i = 0; i < n; i++) step(1, run, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cfg_ready", int'(cfg_ready), e.ready);
            chk("cfg_err", int'(cfg_err), e.err);
            chk("flt_rst_n", int'(flt_rst_n), e.rstn);
            chk("out_valid", int'(out_valid), e.ov);
            chk("busy", int'(busy), e.busy);
            chk("flt_k", int'(flt_k), e.k);
            chk("flt_l", int'(flt_l), e.l);
            chk("flt_m", int'(flt_m), e.m);
            chk("peak_data", int'(peak_data), e.pd);
            chk("peak_valid", int'(peak_valid), e.pv);
         end
      end
   end

   initial begin : stim
      int r;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
      idle_run(0, 2);
      idle_run(1, 25);
      step(1, 1, 1, 3, 10, 20, 0);
      idle_run(1, 25);
      step(1, 1, 1, 5, 2, 99, 0);
      idle_run(1, 1);
      step(1, 1, 1, 30, 34, 99, 0);
      step(1, 1, 1, 0, 5, 99, 0);
      idle_run(1, 2);
      step(1, 1, 1, 2, 3, 7, 0);
      idle_run(1, 5);
      idle_run(0, 3);
      idle_run(1, 20);
      step(1, 0, 1, 4, 4, 33, 0);
      idle_run(0, 2);
      idle_run(1, 1);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      idle_run(1, 20);
      step(1, 1, 0, 0, 0, 0, 10);
      step(1, 1, 0, 0, 0, 0, 80);
      step(1, 1, 0, 0, 0, 0, 120);
      step(1, 1, 0, 0, 0, 0, 90);
      step(1, 1, 0, 0, 0, 0, 30);
      idle_run(1, 3);
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 999));
         step((r != 0), (r >= 60), ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 160)));
      end
      idle_run(0, 2);
      @(posedge clk);
      #4;
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
